dram_req_arbiter: RTL and testbench

- Two-requester front end that shares the single DRAM AXI slave port between the instruction-side (requester 0) and data-side (requester 1) refill/writeback engines.
- Accepts simple req/gnt burst requests and issues one AXI read or write burst at a time downstream.
- Routes R data, W data and completion back to the owner.
- Round-robin fairness; exactly one outstanding transaction.

---
 rtl/dram_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin arbiter sharing one AXI DRAM port between two burst requesters.
// Define DRAM_ARB_STAT_EN to add saturating busy/grant statistics counters.
module dram_req_arbiter #(
  parameter int STAT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [63:0]       addr_i,
  input  logic [7:0]        len_i,
  input  logic [63:0]       wdata_i,
  input  logic [7:0]        wstrb_i,
  output logic [1:0]        gnt_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rvalid_o,
  output logic              rlast_o,
  output logic [1:0]        wready_o,
  output logic [1:0]        done_o,
  output logic [7:0]        m_arid_o,
  output logic [31:0]       m_araddr_o,
  output logic [3:0]        m_arlen_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [2:0]        m_arsize_o,
  output logic [1:0]        m_arburst_o,
  input  logic [7:0]        m_rid_i,
  input  logic [31:0]       m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rlast_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  output logic [7:0]        m_awid_o,
  output logic [31:0]       m_awaddr_o,
  output logic [3:0]        m_awlen_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [2:0]        m_awsize_o,
  output logic [1:0]        m_awburst_o,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  output logic              m_wlast_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [7:0]        m_bid_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o
`ifdef DRAM_ARB_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_busy_o,
  output logic [STAT_W-1:0] stat_gnt0_o,
  output logic [STAT_W-1:0] stat_gnt1_o
`endif
);

  typedef enum logic [2:0] {IDLE, AR, RD, AW, WR, BR, DONE} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d, own_q, own_d, pick;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d, cnt_q, cnt_d;
  logic [1:0]  own_oh;
  logic        unused_ok;

  assign pick   = req_i[ptr_q] ? ptr_q : ~ptr_q;
  assign own_oh = own_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    gnt_o       = '0;
    rvalid_o    = '0;
    rlast_o     = 1'b0;
    wready_o    = '0;
    done_o      = '0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        own_d   = pick;
        addr_d  = pick ? addr_i[63:32] : addr_i[31:0];
        len_d   = pick ? len_i[7:4] : len_i[3:0];
        state_d = we_i[pick] ? AW : AR;
      end
      AR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) begin
          gnt_o   = own_oh;
          state_d = RD;
        end
      end
      RD: begin
        m_rready_o = 1'b1;
        rvalid_o   = m_rvalid_i ? own_oh : 2'b00;
        rlast_o    = m_rlast_i & m_rvalid_i;
        if (m_rvalid_i && m_rlast_i) state_d = DONE;
      end
      AW: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) begin
          gnt_o   = own_oh;
          cnt_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        m_wvalid_o = 1'b1;
        if (m_wready_i) begin
          wready_o = own_oh;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == len_q) state_d = BR;
        end
      end
      BR: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) state_d = DONE;
      end
      DONE: begin
        done_o  = own_oh;
        ptr_d   = ~own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response IDs/status are ignored: the owner register alone routes data back.
  assign unused_ok   = ^{m_rid_i, m_rresp_i, m_bid_i, m_bresp_i, STAT_W != 0};
  assign m_arid_o    = {7'b0, own_q};
  assign m_awid_o    = {7'b0, own_q};
  assign m_araddr_o  = addr_q;
  assign m_awaddr_o  = addr_q;
  assign m_arlen_o   = len_q;
  assign m_awlen_o   = len_q;
  assign m_arsize_o  = 3'b010;
  assign m_awsize_o  = 3'b010;
  assign m_arburst_o = 2'b01;
  assign m_awburst_o = 2'b01;
  assign rdata_o     = (state_q == RD) ? m_rdata_i : '0;
  assign m_wdata_o   = (state_q == WR) ? (own_q ? wdata_i[63:32] : wdata_i[31:0]) : '0;
  assign m_wstrb_o   = (state_q == WR) ? (own_q ? wstrb_i[7:4] : wstrb_i[3:0]) : '0;
  assign m_wlast_o   = (state_q == WR) && (cnt_q == len_q);

`ifdef DRAM_ARB_STAT_EN
  logic [STAT_W-1:0] busy_q, busy_d, g0_q, g0_d, g1_q, g1_d;

  assign busy_d = busy_q + STAT_W'((state_q != IDLE) && !(&busy_q));
  assign g0_d   = g0_q + STAT_W'(gnt_o[0] && !(&g0_q));
  assign g1_d   = g1_q + STAT_W'(gnt_o[1] && !(&g1_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      g0_q   <= '0;
      g1_q   <= '0;
    end else begin
      busy_q <= busy_d;
      g0_q   <= g0_d;
      g1_q   <= g1_d;
    end
  end

  assign stat_busy_o = busy_q;
  assign stat_gnt0_o = g0_q;
  assign stat_gnt1_o = g1_q;
`endif

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: directed bench with an AXI slave model and a scoreboard monitor
// that checks each address handshake, data beat and completion against queued expectations.
module tb_dram_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req, we, gnt, rvalid, wready, done;
  logic [63:0] addr, wdata;
  logic [7:0]  len, wstrb, arid, awid;
  logic [31:0] rdata, araddr, awaddr, wdata_m;
  logic        rlast, arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]  arlen, awlen, wstrb_m;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid;
  logic [31:0] s_rdata;
`ifdef DRAM_ARB_STAT_EN
  logic [15:0] stat_busy, stat_gnt0, stat_gnt1;
`endif

  typedef struct packed {logic we; logic own; logic [31:0] a; logic [3:0] l;} txn_t;
  txn_t        expq[$];
  txn_t        cur;
  logic        act, exp_done_nx, prev_ar_stall, prev_w_stall;
  logic [31:0] prev_araddr, prev_wdata, rd_base;
  int          beat, rd_left, rd_idx, ar_stall, aw_stall, done_n, busy_n, target;
  int          pass_n, total_n;
  int          req_cnt[2];
  logic [31:0] wb[2];
  logic        w_toggle;
  logic [1:0]  gs, ws;
  logic        n_arready, n_awready, n_wready, n_rvalid, n_rlast, n_bvalid;
  logic [31:0] n_rdata;

  assign req   = {req_cnt[1] > 0, req_cnt[0] > 0};
  assign wdata = {32'hB1B1_0000 + wb[1], 32'hA0A0_0000 + wb[0]};

  dram_req_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .len_i(len),
    .wdata_i(wdata), .wstrb_i(wstrb), .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid),
    .rlast_o(rlast), .wready_o(wready), .done_o(done),
    .m_arid_o(arid), .m_araddr_o(araddr), .m_arlen_o(arlen), .m_arvalid_o(arvalid),
    .m_arready_i(s_arready), .m_arsize_o(arsize), .m_arburst_o(arburst),
    .m_rid_i(8'hFF), .m_rdata_i(s_rdata), .m_rresp_i(2'b10), .m_rlast_i(s_rlast),
    .m_rvalid_i(s_rvalid), .m_rready_o(rready),
    .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awlen_o(awlen), .m_awvalid_o(awvalid),
    .m_awready_i(s_awready), .m_awsize_o(awsize), .m_awburst_o(awburst),
    .m_wdata_o(wdata_m), .m_wstrb_o(wstrb_m), .m_wlast_o(wlast), .m_wvalid_o(wvalid),
    .m_wready_i(s_wready), .m_bid_i(8'hFE), .m_bresp_i(2'b11), .m_bvalid_i(s_bvalid),
    .m_bready_o(bready)
`ifdef DRAM_ARB_STAT_EN
    , .stat_busy_o(stat_busy), .stat_gnt0_o(stat_gnt0), .stat_gnt1_o(stat_gnt1)
`endif
  );

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_n++;
    if (got === want) pass_n++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Monitor/scoreboard and AXI slave: sample at negedge, drive slave outputs just after posedge.
  always begin : mon
    @(negedge clk);
    gs = '0;
    ws = '0;
    if (!rst_n) begin
      act = 0; exp_done_nx = 0; prev_ar_stall = 0; prev_w_stall = 0; rd_left = 0; busy_n = 0;
      n_arready = 0; n_awready = 0; n_wready = 0; n_rvalid = 0; n_rlast = 0; n_bvalid = 0; n_rdata = '0;
    end else begin
      if (exp_done_nx) begin
        check("done", done, oh(cur.own));
        check("beats", beat, cur.l + 1);
        done_n++;
        act = 0;
        exp_done_nx = 0;
      end else if (done != 0) check("spurious_done", done, 0);
      if (prev_ar_stall) begin
        check("ar_hold_valid", arvalid, 1);
        check("ar_hold_addr", araddr, prev_araddr);
      end
      if (prev_w_stall) check("w_hold_data", wdata_m, prev_wdata);
      prev_ar_stall = arvalid & !s_arready;
      prev_araddr   = araddr;
      prev_w_stall  = wvalid & !s_wready;
      prev_wdata    = wdata_m;
      if ((arvalid && s_arready) || (awvalid && s_awready)) begin
        if (expq.size() == 0) check("unexpected_addr_hs", 1, 0);
        else begin
          cur = expq.pop_front();
          act = 1;
          beat = 0;
          check("chan_we", awvalid, cur.we);
          check("addr", cur.we ? awaddr : araddr, cur.a);
          check("len", cur.we ? awlen : arlen, cur.l);
          check("id", cur.we ? awid : arid, {7'b0, cur.own});
          check("gnt", gnt, oh(cur.own));
        end
        gs = gnt;
      end else if (gnt != 0) check("spurious_gnt", gnt, 0);
      if (s_rvalid && rready) begin
        if (act && !cur.we) begin
          check("rvalid", rvalid, oh(cur.own));
          check("rdata", rdata, 32'hD000_0000 + cur.a + beat);
          check("rlast", rlast, beat == int'(cur.l));
          if (beat == int'(cur.l)) exp_done_nx = 1;
          beat++;
        end else check("unexpected_r", 1, 0);
      end else if (rvalid != 0) check("spurious_rvalid", rvalid, 0);
      if (wvalid && s_wready) begin
        if (act && cur.we) begin
          check("wready", wready, oh(cur.own));
          check("wdata", wdata_m, (cur.own ? 32'hB1B1_0000 : 32'hA0A0_0000) + beat);
          check("wstrb", wstrb_m, cur.own ? 4'hF : 4'h3);
          check("wlast", wlast, beat == int'(cur.l));
          beat++;
        end else check("unexpected_w", 1, 0);
        ws = wready;
      end else if (wready != 0) check("spurious_wready", wready, 0);
      if (s_bvalid && bready) exp_done_nx = 1;
      if (arvalid || rready || awvalid || wvalid || bready || done != 0) busy_n++;
      n_arready = arvalid && !s_arready && ar_stall == 0;
      if (arvalid && !s_arready && ar_stall > 0) ar_stall--;
      n_awready = awvalid && !s_awready && aw_stall == 0;
      if (awvalid && !s_awready && aw_stall > 0) aw_stall--;
      if (arvalid && s_arready) begin
        rd_left = int'(arlen) + 1;
        rd_idx = 0;
        rd_base = araddr;
      end else if (s_rvalid && rready) begin
        rd_idx++;
        rd_left--;
      end
      n_rvalid = rd_left > 0;
      n_rlast  = rd_left == 1;
      n_rdata  = 32'hD000_0000 + rd_base + rd_idx;
      n_wready = wvalid && !(s_wready && wlast) && (w_toggle ? !s_wready : 1'b1);
      n_bvalid = (wvalid && s_wready && wlast) || (s_bvalid && !bready);
    end
    @(posedge clk);
    #1;
    s_arready = n_arready; s_awready = n_awready; s_wready = n_wready;
    s_rvalid = n_rvalid; s_rlast = n_rlast; s_rdata = n_rdata; s_bvalid = n_bvalid;
    for (int r = 0; r < 2; r++) begin
      if (gs[r]) begin
        req_cnt[r]--;
        wb[r] = '0;
      end else if (ws[r]) wb[r] = wb[r] + 1;
    end
  end

  task automatic wait_done(input int n);
    int t = 0;
    while (done_n < n && t < 400) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("done_timeout", done_n >= n, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    s_arready = 0; s_awready = 0; s_wready = 0; s_rvalid = 0; s_rlast = 0; s_bvalid = 0; s_rdata = '0;
    req_cnt[0] = 0; req_cnt[1] = 0;
    expq.delete();
    #1;
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wlast}, 0);
    check("rst_pulses", {gnt, done, rvalid, wready, rlast}, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    pass_n = 0; total_n = 0; done_n = 0; ar_stall = 0; aw_stall = 0; w_toggle = 0;
    req_cnt[0] = 0; req_cnt[1] = 0; wb[0] = '0; wb[1] = '0;
    s_arready = 0; s_awready = 0; s_wready = 0; s_rvalid = 0; s_rlast = 0; s_bvalid = 0; s_rdata = '0;
    we = '0; addr = '0; len = '0; wstrb = {4'hF, 4'h3};
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_outs", {gnt, rvalid, rlast, wready, done, arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_addr", {araddr, awaddr}, 0);
    check("rst_data", {rdata, wdata_m}, 0);
    check("rst_arsize", arsize, 3'b010);
    check("rst_arburst", arburst, 2'b01);
    check("rst_awsize", awsize, 3'b010);
    check("rst_awburst", awburst, 2'b01);
    rst_n = 1;
    @(posedge clk);
    #2;
    // single read from requester 0
    we = 2'b00; addr = {32'h0, 32'h0000_1000}; len = {4'h0, 4'h3};
    expq.push_back('{we: 1'b0, own: 1'b0, a: 32'h1000, l: 4'd3});
    req_cnt[0] = 1;
    wait_done(1);
    // single write from requester 1
    we = 2'b10; addr = {32'h0000_2000, 32'h0}; len = {4'h1, 4'h0};
    expq.push_back('{we: 1'b1, own: 1'b1, a: 32'h2000, l: 4'd1});
    req_cnt[1] = 1;
    wait_done(2);
    // contention straight after reset, req held across four bursts
    do_reset();
    we = 2'b10; addr = {32'h0000_4000, 32'h0000_3000}; len = 8'h00;
    for (int i = 0; i < 2; i++) begin
      expq.push_back('{we: 1'b0, own: 1'b0, a: 32'h3000, l: 4'd0});
      expq.push_back('{we: 1'b1, own: 1'b1, a: 32'h4000, l: 4'd0});
    end
    req_cnt[0] = 2; req_cnt[1] = 2;
    target = done_n + 4;
    wait_done(target);
    // backpressure: ARREADY stalled, then toggling WREADY
    ar_stall = 5;
    we = 2'b00; addr = {32'h0, 32'h0000_5000}; len = 8'h02;
    expq.push_back('{we: 1'b0, own: 1'b0, a: 32'h5000, l: 4'd2});
    req_cnt[0] = 1;
    wait_done(done_n + 1);
    aw_stall = 2; w_toggle = 1;
    we = 2'b01; addr = {32'h0, 32'h0000_6000}; len = 8'h03;
    expq.push_back('{we: 1'b1, own: 1'b0, a: 32'h6000, l: 4'd3});
    req_cnt[0] = 1;
    wait_done(done_n + 1);
    // reset in the middle of a write burst
    we = 2'b10; addr = {32'h0000_7000, 32'h0}; len = 8'h70;
    expq.push_back('{we: 1'b1, own: 1'b1, a: 32'h7000, l: 4'd7});
    req_cnt[1] = 1;
    begin
      int t = 0;
      while (wb[1] < 2 && t < 200) begin
        @(posedge clk);
        #2;
        t++;
      end
      check("wr_progress_timeout", wb[1] >= 2 && wvalid, 1);
    end
    do_reset();
    w_toggle = 0;
    we = 2'b00; addr = {32'h0000_9000, 32'h0000_8000}; len = 8'h11;
    expq.push_back('{we: 1'b0, own: 1'b0, a: 32'h8000, l: 4'd1});
    req_cnt[0] = 1;
    wait_done(done_n + 1);
    // pointer now favours requester 1
    for (int i = 0; i < 2; i++) begin
      expq.push_back('{we: 1'b0, own: 1'b1, a: 32'h9000, l: 4'd1});
      expq.push_back('{we: 1'b0, own: 1'b0, a: 32'h8000, l: 4'd1});
    end
    req_cnt[0] = 2; req_cnt[1] = 2;
    wait_done(done_n + 4);
    repeat (2) @(posedge clk);
    #2;
    check("queue_empty", expq.size(), 0);
`ifdef DRAM_ARB_STAT_EN
    check("stat_gnt0", stat_gnt0, 3);
    check("stat_gnt1", stat_gnt1, 2);
    check("stat_busy", stat_busy, busy_n);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
